// File: rtl/fetdriver_pkg.sv
// Shared types and helpers for the multi-channel n-type FET gate driver controller.
package fetdriver_pkg;

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    OFF      = 3'd1,
    DT_RISE  = 3'd2,
    ON       = 3'd3,
    DT_FALL  = 3'd4,
    FAULT    = 3'd5
  } ch_state_e;

  localparam int unsigned MIN_DEADTIME = 1;
  localparam int unsigned SEG_MASK_W   = 31;

  // Segment 0 is always enabled; the mask selects the extra segments above it.
  function automatic logic [SEG_MASK_W:0] seg_vec(input logic [SEG_MASK_W-1:0] mask);
    return {mask, 1'b1};
  endfunction

endpackage

// File: rtl/fetdriver_ch.sv
// One gate-driver channel: break-before-make FSM, dead-time counter,
// gate-status filter and gate-reach watchdog.
module fetdriver_ch
  import fetdriver_pkg::*;
#(
  parameter int NSEG       = 2,
  parameter int DTW        = 6,
  parameter int STATUS_DLY = 4,
  parameter int FAULT_TO   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            fetin,
  input  logic            gate_sense,
  input  logic [NSEG-2:0] ron_adjust,
  input  logic [NSEG-2:0] roff_adjust,
  input  logic [DTW-1:0]  deadtime,
  input  logic            fault_clear,
  output logic [NSEG-1:0] pdrive,
  output logic [NSEG-1:0] ndrive,
  output logic            gate_status,
  output logic            fault
);

  localparam int SW = $clog2(STATUS_DLY + 1);
  localparam int TW = (FAULT_TO > 0) ? $clog2(FAULT_TO + 1) : 1;
  localparam logic [SW-1:0]  SDLY_FULL = SW'(STATUS_DLY);
  localparam logic [SW-1:0]  SDLY_M1   = SW'(STATUS_DLY - 1);
  localparam logic [TW-1:0]  TO_FULL   = TW'(FAULT_TO);
  localparam logic [TW-1:0]  TO_M1     = (FAULT_TO > 0) ? TW'(FAULT_TO - 1) : '0;
  localparam logic [DTW-1:0] DT_MIN    = DTW'(MIN_DEADTIME);

  ch_state_e       state_r;
  logic [DTW-1:0]  dt_cnt_r;
  logic [NSEG-2:0] ron_mask_r;
  logic [NSEG-2:0] roff_mask_r;
  logic [NSEG-1:0] pdrive_r;
  logic [NSEG-1:0] ndrive_r;
  logic            fault_r;
  logic            sense_prev_r;
  logic [SW-1:0]   sdly_cnt_r;
  logic            status_r;
  logic [TW-1:0]   to_cnt_r;
  logic            armed_r;

  logic [DTW-1:0]  eff_dt_s;
  logic            mismatch_s;
  logic            fault_hit_s;
  logic            sense_change_s;

  // Effective dead-time, gate/command mismatch and watchdog expiry.
  always_comb begin
    eff_dt_s   = deadtime;
    mismatch_s = 1'b0;
    if (deadtime < DT_MIN) begin
      eff_dt_s = DT_MIN;
    end else begin
      eff_dt_s = deadtime;
    end
    if (state_r == ON) begin
      mismatch_s = ~status_r;
    end else if (state_r == OFF) begin
      mismatch_s = status_r;
    end else begin
      mismatch_s = 1'b0;
    end
    fault_hit_s    = (FAULT_TO > 0) && armed_r && mismatch_s && (to_cnt_r == TO_M1);
    sense_change_s = (gate_sense != sense_prev_r);
  end

  // Gate-status filter: accept gate_sense once it has been stable long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      sense_prev_r <= 1'b0;
      sdly_cnt_r   <= '0;
      status_r     <= 1'b0;
    end else begin
      sense_prev_r <= gate_sense;
      if (sense_change_s) begin
        sdly_cnt_r <= '0;
      end else if (sdly_cnt_r != SDLY_FULL) begin
        sdly_cnt_r <= sdly_cnt_r + SW'(1);
      end
      if (!sense_change_s && (sdly_cnt_r >= SDLY_M1)) begin
        status_r <= gate_sense;
      end
    end
  end

  // Watchdog: re-armed outside ON/OFF, disarmed once the gate reaches its level.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_r <= '0;
      armed_r  <= 1'b0;
    end else if ((state_r != ON) && (state_r != OFF)) begin
      to_cnt_r <= '0;
      armed_r  <= 1'b1;
    end else if (armed_r) begin
      if (!mismatch_s) begin
        armed_r <= 1'b0;
      end else if (to_cnt_r != TO_FULL) begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end
    end
  end

  // Channel FSM with drives decoded from the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= DISABLED;
      dt_cnt_r    <= '0;
      ron_mask_r  <= '0;
      roff_mask_r <= '0;
      pdrive_r    <= '0;
      ndrive_r    <= '0;
      fault_r     <= 1'b0;
    end else begin
      // Masks track the inputs until their state is entered, then freeze.
      if (state_r != ON) ron_mask_r <= ron_adjust;
      if (state_r != OFF) roff_mask_r <= roff_adjust;
      pdrive_r <= (state_r == ON)  ? NSEG'(seg_vec(SEG_MASK_W'(ron_mask_r)))  : '0;
      ndrive_r <= (state_r == OFF) ? NSEG'(seg_vec(SEG_MASK_W'(roff_mask_r))) : '0;
      case (state_r)
        DISABLED: begin
          if (run) state_r <= OFF;
        end
        OFF: begin
          if (fault_hit_s) begin
            state_r <= FAULT;
            fault_r <= 1'b1;
          end else if (!run) begin
            state_r <= DISABLED;
          end else if (fetin) begin
            state_r  <= DT_RISE;
            dt_cnt_r <= eff_dt_s - DTW'(1);
          end
        end
        DT_RISE: begin
          if (!run) begin
            state_r <= DISABLED;
          end else if (!fetin) begin
            state_r <= OFF;
          end else if (dt_cnt_r == '0) begin
            state_r <= ON;
          end else begin
            dt_cnt_r <= dt_cnt_r - DTW'(1);
          end
        end
        ON: begin
          if (fault_hit_s) begin
            state_r <= FAULT;
            fault_r <= 1'b1;
          end else if (!run || !fetin) begin
            state_r  <= DT_FALL;
            dt_cnt_r <= eff_dt_s - DTW'(1);
          end
        end
        DT_FALL: begin
          if (dt_cnt_r != '0) begin
            dt_cnt_r <= dt_cnt_r - DTW'(1);
          end else if (!run) begin
            state_r <= DISABLED;
          end else begin
            state_r <= OFF;
          end
        end
        FAULT: begin
          if (fault_clear) begin
            state_r <= DISABLED;
            fault_r <= 1'b0;
          end
        end
        default: begin
          state_r <= DISABLED;
        end
      endcase
    end
  end

  assign pdrive      = pdrive_r;
  assign ndrive      = ndrive_r;
  assign gate_status = status_r;
  assign fault       = fault_r;

endmodule

// File: rtl/fetdriver_ctrl_nch.sv
// NCH-channel n-type FET gate driver controller; channels share only the
// enables, segment masks, dead-time and fault clear.
module fetdriver_ctrl_nch
  import fetdriver_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int NSEG       = 2,
  parameter int DTW        = 6,
  parameter int STATUS_DLY = 4,
  parameter int FAULT_TO   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_fetdriver,
  input  logic                global_fetdriver,
  input  logic [NCH-1:0]      fetin,
  input  logic [NCH-1:0]      gate_sense,
  input  logic [NSEG-2:0]     ron_adjust,
  input  logic [NSEG-2:0]     roff_adjust,
  input  logic [DTW-1:0]      deadtime,
  input  logic                fault_clear,
  output logic [NCH*NSEG-1:0] pdrive,
  output logic [NCH*NSEG-1:0] ndrive,
  output logic [NCH-1:0]      gate_status,
  output logic [NCH-1:0]      fault
);

  logic run_s;

  assign run_s = enable_fetdriver & ~global_fetdriver;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    fetdriver_ch #(
      .NSEG      (NSEG),
      .DTW       (DTW),
      .STATUS_DLY(STATUS_DLY),
      .FAULT_TO  (FAULT_TO)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .run        (run_s),
      .fetin      (fetin[c]),
      .gate_sense (gate_sense[c]),
      .ron_adjust (ron_adjust),
      .roff_adjust(roff_adjust),
      .deadtime   (deadtime),
      .fault_clear(fault_clear),
      .pdrive     (pdrive[c*NSEG +: NSEG]),
      .ndrive     (ndrive[c*NSEG +: NSEG]),
      .gate_status(gate_status[c]),
      .fault      (fault[c])
    );
  end

endmodule

// File: tb/tb_fetdriver_ctrl_nch.sv
// Scoreboard bench: a phase-level reference model pushes the expected outputs
// after each clock edge; a negedge monitor pops and compares.
module tb_fetdriver_ctrl_nch;

  localparam int NCH = 4, NSEG = 2, DTW = 6, STATUS_DLY = 4, FAULT_TO = 32;
  localparam int M_DIS = 0, M_OFF = 1, M_RISE = 2, M_ON = 3, M_FALL = 4, M_FLT = 5;

  typedef struct packed {
    logic [NCH*NSEG-1:0] p;
    logic [NCH*NSEG-1:0] n;
    logic [NCH-1:0]      st;
    logic [NCH-1:0]      f;
  } exp_t;

  logic clk = 1'b0;
  logic reset, en, gl, fclr;
  logic [NCH-1:0] fetin, sense;
  logic [NSEG-2:0] ron, roff;
  logic [DTW-1:0] dt;
  logic [NCH*NSEG-1:0] pdrive, ndrive;
  logic [NCH-1:0] gate_status, fault;

  int md[NCH], remain[NCH], pm[NCH], nm[NCH], mp[NCH], mn[NCH], late[NCH], runlen[NCH];
  bit st[NCH], flt[NCH], waiting[NCH], last[NCH];
  int plant[NCH];
  bit man[NCH];
  exp_t expq[$];
  int total = 0, bad = 0, ncyc = 0;

  fetdriver_ctrl_nch #(.NCH(NCH), .NSEG(NSEG), .DTW(DTW), .STATUS_DLY(STATUS_DLY),
                       .FAULT_TO(FAULT_TO)) dut (
    .clk(clk), .reset(reset), .enable_fetdriver(en), .global_fetdriver(gl),
    .fetin(fetin), .gate_sense(sense), .ron_adjust(ron), .roff_adjust(roff),
    .deadtime(dt), .fault_clear(fclr), .pdrive(pdrive), .ndrive(ndrive),
    .gate_status(gate_status), .fault(fault));

  always #5 clk = ~clk;

  // Advance the reference model by one clock edge using the applied inputs.
  task automatic model_edge();
    bit run, hit;
    int dlen, nx;
    run  = en && !gl;
    dlen = (dt == 0) ? 1 : int'(dt);
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        md[c] = M_DIS; remain[c] = 0; pm[c] = 0; nm[c] = 0; mp[c] = 0; mn[c] = 0;
        st[c] = 0; flt[c] = 0; waiting[c] = 0; late[c] = 0; last[c] = 0; runlen[c] = 1;
      end else begin
        hit = 0;
        nx  = md[c];
        mp[c] = (md[c] == M_ON)  ? pm[c] * 2 + 1 : 0;
        mn[c] = (md[c] == M_OFF) ? nm[c] * 2 + 1 : 0;
        if ((md[c] == M_ON || md[c] == M_OFF) && waiting[c]) begin
          if (st[c] == (md[c] == M_ON)) waiting[c] = 0;
          else begin
            late[c]++;
            hit = (FAULT_TO > 0) && (late[c] == FAULT_TO);
          end
        end
        if (md[c] != M_ON) pm[c] = int'(ron);
        if (md[c] != M_OFF) nm[c] = int'(roff);
        case (md[c])
          M_DIS:  if (run) nx = M_OFF;
          M_OFF:  if (hit) nx = M_FLT;
                  else if (!run) nx = M_DIS;
                  else if (fetin[c]) begin nx = M_RISE; remain[c] = dlen; end
          M_RISE: if (!run) nx = M_DIS;
                  else if (!fetin[c]) nx = M_OFF;
                  else begin remain[c]--; if (remain[c] == 0) nx = M_ON; end
          M_ON:   if (hit) nx = M_FLT;
                  else if (!run || !fetin[c]) begin nx = M_FALL; remain[c] = dlen; end
          M_FALL: begin remain[c]--; if (remain[c] == 0) nx = run ? M_OFF : M_DIS; end
          M_FLT:  if (fclr) begin nx = M_DIS; flt[c] = 0; end
          default: nx = M_DIS;
        endcase
        if (hit) flt[c] = 1;
        if ((nx == M_ON || nx == M_OFF) && nx != md[c]) begin waiting[c] = 1; late[c] = 0; end
        md[c] = nx;
        if (sense[c] == last[c]) begin
          if (runlen[c] < 1000) runlen[c]++;
        end else begin
          runlen[c] = 1; last[c] = sense[c];
        end
        if (runlen[c] >= STATUS_DLY + 1) st[c] = sense[c];
      end
    end
  endtask

  // Run n clock edges: update model, queue expectation, then drive the gate plant.
  task automatic cyc(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      for (int c = 0; c < NCH; c++) begin
        e.p[c*NSEG +: NSEG] = mp[c][NSEG-1:0];
        e.n[c*NSEG +: NSEG] = mn[c][NSEG-1:0];
        e.st[c] = st[c];
        e.f[c]  = flt[c];
      end
      expq.push_back(e);
      #1;
      for (int c = 0; c < NCH; c++) begin
        case (plant[c])
          1:       sense[c] = man[c];
          2:       sense[c] = (mp[c] != 0) ^ ($urandom_range(0, 5) == 0);
          default: sense[c] = (mp[c] != 0);
        endcase
      end
      ncyc++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, ncyc, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pdrive", 32'(pdrive), 32'(e.p));
        chk("ndrive", 32'(ndrive), 32'(e.n));
        chk("gate_status", 32'(gate_status), 32'(e.st));
        chk("fault", 32'(fault), 32'(e.f));
      end
    end
  end

  initial begin
    reset = 1; en = 0; gl = 0; fclr = 0; fetin = '0; sense = '0; ron = '0; roff = '0; dt = 6'd3;
    for (int c = 0; c < NCH; c++) begin plant[c] = 0; man[c] = 0; end
    cyc(3);
    reset = 0;
    // Dead-time on the first turn-on, then mask capture on channel 1.
    en = 1; cyc(4); fetin[0] = 1; cyc(10);
    ron = 1'b1; fetin[1] = 1; cyc(10); ron = 1'b0; cyc(5); fetin[1] = 0; cyc(8);
    fetin[1] = 1; cyc(12); fetin[1] = 0; roff = 1'b1; cyc(8);
    // Zero dead-time, and an aborted rise.
    dt = 6'd0; fetin[2] = 1; cyc(8); fetin[2] = 0; cyc(8);
    dt = 6'd5; fetin[3] = 1; cyc(1); fetin[3] = 0; cyc(8);
    // Sense glitch shorter than the filter, then a stable change.
    plant[2] = 1; man[2] = 1; cyc(3); man[2] = 0; cyc(6); man[2] = 1; cyc(8); man[2] = 0; cyc(6);
    plant[2] = 0;
    // Gate stuck low while commanded on.
    plant[1] = 1; man[1] = 0; fetin[1] = 1; cyc(50); fetin[1] = 0; cyc(2);
    fclr = 1; cyc(1); fclr = 0; cyc(4); plant[1] = 0;
    // Gate stuck high while off, fault clear held.
    plant[3] = 1; man[3] = 1; cyc(40); fclr = 1; cyc(3); fclr = 0; man[3] = 0; cyc(8); plant[3] = 0;
    // Global force-off, then reset during the rise dead-time.
    fetin = '1; cyc(15); gl = 1; cyc(10); gl = 0; cyc(5); fetin = '0; cyc(10);
    fetin = '1; cyc(2); reset = 1; cyc(1); reset = 0; cyc(6);
    // Randomised operation.
    for (int b = 0; b < 30; b++) begin
      bit gl_blk;
      dt = 6'($urandom_range(0, 7));
      gl_blk = ($urandom_range(0, 4) == 0);
      for (int c = 0; c < NCH; c++) begin
        int k;
        k = $urandom_range(0, 5);
        plant[c] = (k == 3) ? 1 : (k == 4) ? 2 : 0;
        man[c] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 100; i++) begin
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, 29) == 0) fetin[c] = ~fetin[c];
        en    = ($urandom_range(0, 99) != 0);
        gl    = gl_blk && ($urandom_range(0, 3) == 0);
        fclr  = ($urandom_range(0, 49) == 0);
        reset = ($urandom_range(0, 499) == 0);
        if ($urandom_range(0, 19) == 0) ron = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 19) == 0) roff = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 49) == 0) dt = 6'($urandom_range(0, 7));
        cyc(1);
      end
    end
    reset = 0;
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #2;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
